// File: rtl/spi_responder_if.sv
// SPI responder bus: the external SPI pins plus the parallel word interface.
interface spi_responder_if #(
    parameter int WID = 24
);
    logic           sck;
    logic           ss_L;
    logic           mosi;
    logic           miso;
    logic [WID-1:0] to_master;
    logic [WID-1:0] from_master;
    logic           busy;
    logic           finished;
    logic           err;

    modport slave (
        input  sck, ss_L, mosi, to_master,
        output miso, from_master, busy, finished, err
    );

    modport master (
        output sck, ss_L, mosi, to_master,
        input  miso, from_master, busy, finished, err
    );
endinterface

// File: rtl/spi_responder.sv
// SPI slave for one full-duplex MSB-first word. All SPI pins are oversampled
// in the clk domain; sck is only ever treated as data.
module spi_responder #(
    parameter int WID      = 24,
    parameter int POLARITY = 0,
    parameter int PHASE    = 0
) (
    input  logic            clk,
    input  logic            rst,
    spi_responder_if.slave  bus
);

    localparam int            CNT_W    = $clog2(WID + 1);
    localparam logic [CNT_W-1:0] WID_CNT = CNT_W'(WID);
    localparam logic          SCK_IDLE = (POLARITY != 0);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sck_sync, ss_sync, mosi_sync;
    logic             sck_prev, ss_prev;
    logic [WID-1:0]   tx_sr, rx_sr, from_master_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             finished_q, err_q;

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic ss_fall, ss_rise;
    logic do_load, do_sample, do_shift, do_finish, do_err;

    // Two-flop synchronizers plus one history flop per pin for edge detection.
    // ss_prev resets to "selected" so a transfer already running at reset is
    // ignored until the master deselects and reselects.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= {2{SCK_IDLE}};
            sck_prev  <= SCK_IDLE;
            ss_sync   <= 2'b00;
            ss_prev   <= 1'b0;
            mosi_sync <= 2'b00;
        end else begin
            sck_sync  <= {sck_sync[0], bus.sck};
            sck_prev  <= sck_sync[1];
            ss_sync   <= {ss_sync[0], bus.ss_L};
            ss_prev   <= ss_sync[1];
            mosi_sync <= {mosi_sync[0], bus.mosi};
        end
    end

    assign lead_edge   = (sck_prev == SCK_IDLE) && (sck_sync[1] != SCK_IDLE);
    assign trail_edge  = (sck_prev != SCK_IDLE) && (sck_sync[1] == SCK_IDLE);
    assign sample_edge = (PHASE == 0) ? lead_edge  : trail_edge;
    assign shift_edge  = (PHASE == 0) ? trail_edge : lead_edge;
    assign ss_fall     = ss_prev && !ss_sync[1];
    assign ss_rise     = !ss_prev && ss_sync[1];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and per-cycle datapath controls; deselect beats any sck edge.
    // The bit_cnt != 0 shift guard also skips the first leading edge in PHASE 1.
    always_comb begin
        state_d   = state_q;
        do_load   = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        do_finish = 1'b0;
        do_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = ACTIVE;
                    do_load = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    if (bit_cnt == WID_CNT) do_finish = 1'b1;
                    else                    do_err    = 1'b1;
                end else begin
                    do_sample = sample_edge && (bit_cnt < WID_CNT);
                    do_shift  = shift_edge && (bit_cnt != '0) && (bit_cnt < WID_CNT);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift registers, bit counter, received word and the one-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sr         <= '0;
            rx_sr         <= '0;
            bit_cnt       <= '0;
            from_master_q <= '0;
            finished_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            finished_q <= do_finish;
            err_q      <= do_err;
            if (do_finish) from_master_q <= rx_sr;
            if (do_load) begin
                tx_sr   <= bus.to_master;
                bit_cnt <= '0;
            end else begin
                if (do_sample) begin
                    rx_sr   <= {rx_sr[WID-2:0], mosi_sync[1]};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                if (do_shift) tx_sr <= {tx_sr[WID-2:0], 1'b0};
            end
        end
    end

    assign bus.miso        = (state_q == ACTIVE) ? tx_sr[WID-1] : 1'b0;
    assign bus.busy        = (state_q == ACTIVE);
    assign bus.from_master = from_master_q;
    assign bus.finished    = finished_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: one instance per SPI mode, a bit-banged master,
// and a scoreboard of expected finished/err pulses.
module tb_spi_responder;

    localparam int W = 24;

    typedef struct {
        int          mode;
        logic        is_err;
        logic [W-1:0] word;
    } sb_entry_t;

    logic clk = 1'b0;
    logic rst;

    logic         sck_a  [4];
    logic         ss_a   [4];
    logic         mosi_a [4];
    logic [W-1:0] tm_a   [4];
    logic         miso_a [4];
    logic [W-1:0] fm_a   [4];
    logic         busy_a [4];
    logic         fin_a  [4];
    logic         err_a  [4];

    sb_entry_t sb[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : mode
        spi_responder_if #(.WID(W)) bus ();
        assign bus.sck       = sck_a[g];
        assign bus.ss_L      = ss_a[g];
        assign bus.mosi      = mosi_a[g];
        assign bus.to_master = tm_a[g];
        assign miso_a[g]     = bus.miso;
        assign fm_a[g]       = bus.from_master;
        assign busy_a[g]     = bus.busy;
        assign fin_a[g]      = bus.finished;
        assign err_a[g]      = bus.err;
        spi_responder #(.WID(W), .POLARITY(g / 2), .PHASE(g % 2)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_pulse(input int m, input logic is_err, input logic [W-1:0] word);
        sb_entry_t e;
        e.mode   = m;
        e.is_err = is_err;
        e.word   = word;
        sb.push_back(e);
    endtask

    // Bit-banged SPI master: nbits bits of tx (MSB first), sck half period of 6 clk.
    task automatic xfer(input int m, input int nbits, input logic [31:0] tx,
                        input int rst_at, input int gap, output logic [31:0] rx);
        logic pol, pha;
        logic [W-1:0] tm_save;
        pol = (m / 2) != 0;
        pha = (m % 2) != 0;
        rx = '0;
        tm_save = tm_a[m];
        ss_a[m] = 1'b0;
        if (!pha) mosi_a[m] = tx[nbits-1];
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            if (i == 2 && rst_at < 0) check("busy_active", busy_a[m], 1);
            if (i == nbits / 2) tm_a[m] = ~tm_save;
            if (!pha) rx = {rx[30:0], miso_a[m]};
            else      mosi_a[m] = tx[nbits-1-i];
            sck_a[m] = ~pol;
            repeat (6) @(negedge clk);
            if (pha)                 rx = {rx[30:0], miso_a[m]};
            else if (i < nbits - 1)  mosi_a[m] = tx[nbits-2-i];
            sck_a[m] = pol;
            repeat (6) @(negedge clk);
        end
        ss_a[m] = 1'b1;
        tm_a[m] = tm_save;
        repeat (gap) @(negedge clk);
    endtask

    // Scoreboard monitor: every finished/err pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        sb_entry_t e;
        for (int g = 0; g < 4; g++) begin
            if (fin_a[g] || err_a[g]) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: mode %0d finished=%b err=%b, no pulse expected",
                             g, fin_a[g], err_a[g]);
                end else begin
                    e = sb.pop_front();
                    check("pulse_mode", g, e.mode);
                    check("pulse_err", err_a[g], e.is_err);
                    check("pulse_finished", fin_a[g], !e.is_err);
                    check("from_master", fm_a[g], e.word);
                    check("busy_after_end", busy_a[g], 0);
                end
            end
        end
    end

    initial begin
        logic [31:0] rx;
        rst = 1'b1;
        for (int g = 0; g < 4; g++) begin
            sck_a[g]  = (g / 2) != 0;
            ss_a[g]   = 1'b1;
            mosi_a[g] = 1'b0;
            tm_a[g]   = '0;
        end
        repeat (4) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            check("rst_from_master", fm_a[g], 0);
            check("rst_busy", busy_a[g], 0);
            check("rst_miso", miso_a[g], 0);
            check("rst_finished", fin_a[g], 0);
            check("rst_err", err_a[g], 0);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // All four modes exchange the same pair of words.
        for (int m = 0; m < 4; m++) begin
            tm_a[m] = 24'hA5C3F0;
            expect_pulse(m, 1'b0, 24'h123456);
            xfer(m, 24, 32'h123456, -1, 10, rx);
            check("master_read", rx[23:0], 32'hA5C3F0);
        end

        // Short transfer: err, from_master keeps 123456.
        expect_pulse(0, 1'b1, 24'h123456);
        xfer(0, 10, 32'h3FF, -1, 10, rx);
        check("busy_after_err", busy_a[0], 0);

        // 26 sck cycles: only the first 24 bits count, miso holds the last bit.
        expect_pulse(0, 1'b0, 24'hABCDEF);
        xfer(0, 26, {6'b0, 24'hABCDEF, 2'b11}, -1, 10, rx);
        check("master_read_26", rx[25:2], 32'hA5C3F0);
        check("miso_hold", rx[1:0], 0);

        // Reset in the middle of a transfer: no pulses, next transfer is clean.
        xfer(0, 24, 32'h123456, 12, 10, rx);
        check("from_master_after_rst", fm_a[0], 0);
        check("busy_after_rst", busy_a[0], 0);
        tm_a[0] = 24'h0F1E2D;
        expect_pulse(0, 1'b0, 24'h654321);
        xfer(0, 24, 32'h654321, -1, 10, rx);
        check("master_read_post_rst", rx[23:0], 32'h0F1E2D);

        // Back-to-back in mode 3 with ss_L high for 4 clk between.
        tm_a[3] = 24'h5A5A5A;
        expect_pulse(3, 1'b0, 24'hDEAD01);
        xfer(3, 24, 32'hDEAD01, -1, 4, rx);
        check("master_read_b2b_1", rx[23:0], 32'h5A5A5A);
        tm_a[3] = 24'hC0FFEE;
        expect_pulse(3, 1'b0, 24'h00BEEF);
        xfer(3, 24, 32'h00BEEF, -1, 10, rx);
        check("master_read_b2b_2", rx[23:0], 32'hC0FFEE);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
